sipo_deframer: RTL and testbench



---
 rtl/sipo_deframer.sv | 94 +++++++++
 tb/tb_sipo_deframer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sipo_deframer.sv
// Serial-in/parallel-out receiver: assembles WIDTH-bit words from a qualified
// bit stream, realigns on start-of-frame, and holds one completed word for a valid/ready consumer.
module sipo_deframer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sin,
  input  logic                       sin_valid,
  input  logic                       sof,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       overrun,
  input  logic                       clr_overrun,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);
  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  typedef enum logic {EMPTY, FULL} hold_t;

  logic [WIDTH-1:0] sr, sr_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             complete, load, drop;
  hold_t            state, state_nxt;

  // Shifter and bit counter; sof restarts the word with the current bit as bit 0.
  always_comb begin
    sr_nxt   = sr;
    cnt_nxt  = bit_cnt;
    complete = 1'b0;
    if (sin_valid) begin
      if (sof) begin
        sr_nxt  = MSB_FIRST ? {{(WIDTH-1){1'b0}}, sin} : {sin, {(WIDTH-1){1'b0}}};
        cnt_nxt = CW'(1);
      end else begin
        sr_nxt = MSB_FIRST ? {sr[WIDTH-2:0], sin} : {sin, sr[WIDTH-1:1]};
        if (bit_cnt == LAST) begin
          cnt_nxt  = '0;
          complete = 1'b1;
        end else begin
          cnt_nxt = bit_cnt + CW'(1);
        end
      end
    end
  end

  // One-entry holding stage; a handshake on the completing edge refills without a bubble.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    case (state)
      EMPTY: if (complete) begin
        load      = 1'b1;
        state_nxt = FULL;
      end
      FULL: begin
        if (dout_ready) begin
          if (complete) load = 1'b1;
          else          state_nxt = EMPTY;
        end else if (complete) begin
          drop = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr      <= '0;
      bit_cnt <= '0;
      dout    <= '0;
      overrun <= 1'b0;
    end else begin
      sr      <= sr_nxt;
      bit_cnt <= cnt_nxt;
      if (load) dout <= sr_nxt;
      // A drop on the same edge as a clear keeps the flag set.
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  assign dout_valid = (state == FULL);

endmodule

// File: tb/tb_sipo_deframer.sv
// Directed + random bench for sipo_deframer; MSB-first and LSB-first instances share one stimulus stream.
module tb_sipo_deframer;
  localparam int W  = 8;
  localparam int CW = $clog2(W+1);

  logic clk = 1'b0, reset = 1'b1;
  logic sin = 1'b0, sin_valid = 1'b0, sof = 1'b0, dout_ready = 1'b0, clr_overrun = 1'b0;
  logic [W-1:0]  dout_m, dout_l;
  logic          dv_m, dv_l, ovr_m, ovr_l;
  logic [CW-1:0] cnt_m, cnt_l;

  sipo_deframer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready),
    .overrun(ovr_m), .clr_overrun(clr_overrun), .bit_cnt(cnt_m));

  sipo_deframer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready),
    .overrun(ovr_l), .clr_overrun(clr_overrun), .bit_cnt(cnt_l));

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;

  // Reference: list of bits received in the current word plus the holding register contents.
  bit       q[$];
  logic [W-1:0] m_dout_m = '0, m_dout_l = '0;
  bit       m_valid = 0, m_ovr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".dout_m"},  32'(dout_m), 32'(m_dout_m));
    chk({tag, ".dout_l"},  32'(dout_l), 32'(m_dout_l));
    chk({tag, ".valid_m"}, 32'(dv_m),   32'(m_valid));
    chk({tag, ".valid_l"}, 32'(dv_l),   32'(m_valid));
    chk({tag, ".ovr_m"},   32'(ovr_m),  32'(m_ovr));
    chk({tag, ".ovr_l"},   32'(ovr_l),  32'(m_ovr));
    chk({tag, ".cnt_m"},   32'(cnt_m),  32'(q.size()));
    chk({tag, ".cnt_l"},   32'(cnt_l),  32'(q.size()));
  endtask

  task automatic model_reset();
    q.delete();
    m_dout_m = '0; m_dout_l = '0; m_valid = 0; m_ovr = 0;
  endtask

  // Apply one cycle of inputs, advance the reference, then sample 1 time unit after the edge.
  task automatic step(input string tag, input bit b, input bit v, input bit s, input bit r, input bit c);
    logic [W-1:0] wm, wl;
    bit done = 0, hs;
    sin = b; sin_valid = v; sof = s; dout_ready = r; clr_overrun = c;
    if (v) begin
      if (s) q.delete();
      q.push_back(b);
      if (q.size() == W) begin
        done = 1;
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = q[i];
          wl[i]     = q[i];
        end
        q.delete();
      end
    end
    hs = m_valid && r;
    if (c) m_ovr = 0;
    if (done && (!m_valid || hs)) begin
      m_dout_m = wm; m_dout_l = wl; m_valid = 1;
    end else if (done) begin
      m_ovr = 1;
    end else if (hs) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  // Send w's bits from bit 7 down to bit 0; optional random gap cycles and sof on the first bit.
  task automatic send(input string tag, input logic [W-1:0] w, input bit r, input bit gaps, input bit first_sof);
    for (int i = W-1; i >= 0; i--) begin
      if (gaps) step({tag, ".gap"}, 1'($urandom), 1'b0, 1'($urandom), r, 1'b0);
      step(tag, w[i], 1'b1, first_sof && (i == W-1), r, 1'b0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk_all("reset");
    reset = 1'b0;

    // Basic word, MSB-first
    send("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
    chk("a5.const", 32'(dout_m), 32'hA5);
    chk("a5.vld", 32'(dv_m), 32'd1);
    chk("a5.cnt0", 32'(cnt_m), 32'd0);
    step("a5.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("a5.onecycle", 32'(dv_m), 32'd0);

    // Bit order difference between instances
    send("c0", 8'hC0, 1'b1, 1'b0, 1'b0);
    chk("order.msb", 32'(dout_m), 32'hC0);
    chk("order.lsb", 32'(dout_l), 32'h03);
    step("c0.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Gapped input
    send("gap3c", 8'h3C, 1'b1, 1'b1, 1'b0);
    chk("gap.const", 32'(dout_m), 32'h3C);
    step("gap.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure and overrun
    send("bp11", 8'h11, 1'b0, 1'b0, 1'b0);
    chk("bp.first", 32'(dout_m), 32'h11);
    send("bp22", 8'h22, 1'b0, 1'b0, 1'b0);
    chk("bp.hold", 32'(dout_m), 32'h11);
    chk("bp.ovr", 32'(ovr_m), 32'd1);
    step("bp.drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp.empty", 32'(dv_m), 32'd0);
    chk("bp.ovr_sticky", 32'(ovr_m), 32'd1);
    step("bp.clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp.cleared", 32'(ovr_m), 32'd0);

    // Consume and complete on the same edge
    send("sim55", 8'h55, 1'b0, 1'b0, 1'b0);
    for (int i = W-1; i >= 0; i--)
      step("simaa", 1'(8'hAA >> i), 1'b1, 1'b0, i == 0, 1'b0);
    chk("sim.dout", 32'(dout_m), 32'hAA);
    chk("sim.vld", 32'(dv_m), 32'd1);
    chk("sim.ovr", 32'(ovr_m), 32'd0);
    step("sim.drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Clear and drop on the same edge: set wins
    send("cd1", 8'h01, 1'b0, 1'b0, 1'b0);
    for (int i = W-1; i >= 0; i--)
      step("cd2", 1'(8'h02 >> i), 1'b1, 1'b0, 1'b0, i == 0);
    chk("clrdrop.ovr", 32'(ovr_m), 32'd1);
    step("cd.drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Resync on sof
    step("rs.b0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step("rs.b1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step("rs.b2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send("rsf0", 8'hF0, 1'b1, 1'b0, 1'b1);
    chk("rs.dout", 32'(dout_m), 32'hF0);

    // Asynchronous reset while FULL and mid-word
    send("ar9c", 8'h9C, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("ar.part", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk_all("areset");
    chk("areset.dout", 32'(dout_m), 32'd0);
    #1 reset = 1'b0;
    step("ar.resume", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ar.cnt1", 32'(cnt_m), 32'd1);

    // Random traffic against the reference
    for (int n = 0; n < 400; n++)
      step("rnd", 1'($urandom), $urandom_range(3) != 0, $urandom_range(9) == 0,
           1'($urandom), $urandom_range(15) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
